// File: rtl/bitstream_pkg.sv
// Shared definitions for the multi-channel bitstream generator: maximal-length
// LFSR tap masks (widths 4..32), default seed and the load FSM state encoding.
package bitstream_pkg;

  localparam int DEFAULT_SEED = 1;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_PENDING = 1'b1;

  // Bit k set means stage k+1 feeds the XOR; each polynomial is primitive.
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] m;
    m = '0;
    case (w)
      4:  m = 32'h0000_000C;
      5:  m = 32'h0000_0014;
      6:  m = 32'h0000_0030;
      7:  m = 32'h0000_0060;
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_D008;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_fib.sv
// Fibonacci LFSR, shifts left with XOR feedback into bit 0; state updates one
// cycle after i_en/i_ld. A zero load value is replaced by SEED to avoid lock-up.
module lfsr_fib
  import bitstream_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int SEED  = DEFAULT_SEED
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_val,
  output logic [WIDTH-1:0] o_state
);

  localparam logic [31:0]      TAPS   = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  logic [WIDTH-1:0] r_state;
  logic             w_fb;

  assign w_fb    = ^(r_state & TAPS[WIDTH-1:0]);
  assign o_state = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SEED_V;
    end else if (i_ld) begin
      r_state <= (i_ld_val == '0) ? SEED_V : i_ld_val;
    end else if (i_en) begin
      r_state <= {r_state[WIDTH-2:0], w_fb};
    end
  end

endmodule

// File: rtl/bitstream_gen_mc.sv
// Multi-channel stochastic bitstream generator, outputs registered (1 cycle); loads use ld_valid/ld_ready.
// With APPLY_AT_PERIOD=1 one load is held until the period boundary. BITSTREAM_GEN_SEED_EN adds runtime reseed.
module bitstream_gen_mc
  import bitstream_pkg::*;
#(
  parameter int BITWIDTH        = 20,
  parameter int NUM_CH          = 4,
  parameter int SEED            = DEFAULT_SEED,
  parameter int APPLY_AT_PERIOD = 1,
  localparam int CHW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic                CLK,
  input  logic                RST,
  input  logic                en,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [CHW-1:0]      ld_ch,
  input  logic [BITWIDTH-1:0] ld_value,
  input  logic                ld_neg,
`ifdef BITSTREAM_GEN_SEED_EN
  input  logic                seed_valid,
  input  logic [BITWIDTH-1:0] seed,
`endif
  output logic [NUM_CH-1:0]   out_p,
  output logic [NUM_CH-1:0]   out_m,
  output logic                period_start
);

  localparam logic [BITWIDTH-1:0] P_LAST = {{(BITWIDTH-1){1'b1}}, 1'b0};
  localparam int STEP = ((BITWIDTH / NUM_CH) > 0) ? (BITWIDTH / NUM_CH) : 1;

  logic [BITWIDTH-1:0] w_state;
  logic [BITWIDTH-1:0] w_seed_val;
  logic                w_seed_ld;
  logic                w_adv;
  logic                w_wrap;
  logic                w_accept;
  logic [NUM_CH-1:0]   w_ones;

  logic [BITWIDTH-1:0] r_cnt;
  state_t              r_fsm;
  logic [CHW-1:0]      r_sh_ch;
  logic [BITWIDTH-1:0] r_sh_val;
  logic                r_sh_neg;
  logic [BITWIDTH-1:0] r_val [NUM_CH];
  logic [NUM_CH-1:0]   r_neg;
  logic [NUM_CH-1:0]   r_out_p;
  logic [NUM_CH-1:0]   r_out_m;
  logic                r_ps;

`ifdef BITSTREAM_GEN_SEED_EN
  assign w_seed_ld  = seed_valid;
  assign w_seed_val = seed;
`else
  assign w_seed_ld  = 1'b0;
  assign w_seed_val = '0;
`endif

  // A reseed cycle neither advances the stream nor counts toward the period.
  assign w_adv    = en & ~w_seed_ld;
  assign w_wrap   = w_adv & (r_cnt == P_LAST);
  assign ld_ready = ~RST & (r_fsm == ST_IDLE);
  assign w_accept = ld_valid & ld_ready;

  lfsr_fib #(
    .WIDTH (BITWIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_en     (w_adv),
    .i_ld     (w_seed_ld),
    .i_ld_val (w_seed_val),
    .o_state  (w_state)
  );

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam int ROT = (gi * STEP) % BITWIDTH;
    logic [BITWIDTH-1:0] w_sample;
    if (ROT == 0) begin : g_norot
      assign w_sample = w_state;
    end else begin : g_rot
      assign w_sample = {w_state[BITWIDTH-1-ROT:0], w_state[BITWIDTH-1:BITWIDTH-ROT]};
    end
    assign w_ones[gi] = (w_sample <= r_val[gi]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_fsm    <= ST_IDLE;
      r_sh_ch  <= '0;
      r_sh_val <= '0;
      r_sh_neg <= 1'b0;
      r_neg    <= '0;
      for (int i = 0; i < NUM_CH; i++) r_val[i] <= '0;
    end else begin
      if (w_seed_ld) begin
        r_cnt <= '0;
      end else if (w_adv) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end

      if (APPLY_AT_PERIOD == 0) begin
        if (w_accept) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ld_ch) == i) begin
              r_val[i] <= ld_value;
              r_neg[i] <= ld_neg;
            end
          end
        end
      end else begin
        case (r_fsm)
          ST_IDLE: begin
            if (w_accept) begin
              r_sh_ch  <= ld_ch;
              r_sh_val <= ld_value;
              r_sh_neg <= ld_neg;
              r_fsm    <= ST_PENDING;
            end
          end
          ST_PENDING: begin
            // Out-of-range channels fall through the loop and are dropped here.
            if (w_wrap) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (int'(r_sh_ch) == i) begin
                  r_val[i] <= r_sh_val;
                  r_neg[i] <= r_sh_neg;
                end
              end
              r_fsm <= ST_IDLE;
            end
          end
          default: r_fsm <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_p <= '0;
      r_out_m <= '0;
      r_ps    <= 1'b0;
    end else begin
      r_ps    <= w_adv & (r_cnt == '0);
      r_out_p <= {NUM_CH{w_adv}} & w_ones & ~r_neg;
      r_out_m <= {NUM_CH{w_adv}} & w_ones & r_neg;
    end
  end

  assign out_p        = r_out_p;
  assign out_m        = r_out_m;
  assign period_start = r_ps;

endmodule
